// File: rtl/keypad_scan_if.sv
// rtl/keypad_scan_if.sv - CPU-side key report handshake between the scanner and the RAT CPU
//
// Signals:
//   key_code     4  last accepted key code (scanner -> CPU)
//   key_valid    1  key waiting to be read (scanner -> CPU)
//   key_overrun  1  sticky, a key was replaced before being read (scanner -> CPU)
//   interrupt    1  pulse per accepted key (scanner -> CPU)
//   key_ack      1  one-cycle pulse on CPU port read (CPU -> scanner)
interface keypad_scan_if;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_overrun;
    logic       interrupt;
    logic       key_ack;

    modport master (
        output key_code,
        output key_valid,
        output key_overrun,
        output interrupt,
        input  key_ack
    );

    modport slave (
        input  key_code,
        input  key_valid,
        input  key_overrun,
        input  interrupt,
        output key_ack
    );
endinterface

// File: rtl/keypad_scan_ctrl.sv
// rtl/keypad_scan_ctrl.sv - 3x4 keypad scan sequencer with debounce, key report and interrupt
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   scan_en  in   1 = scanning active; 0 = rows off, scan and FSM held idle
//   cols     in   column sense {E,A,C}, asynchronous, 1 = pressed on driven row
//   rows     out  one-hot row drive {D,F,G,B}, B = rows[0]
//   cpu      master side of keypad_scan_if (key_code/key_valid/key_overrun/interrupt/key_ack)
module keypad_scan_ctrl #(
    parameter int SCAN_CYCLES    = 50000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int INT_CYCLES     = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          scan_en,
    input  logic [2:0]    cols,
    output logic [3:0]    rows,
    keypad_scan_if.master cpu
);
    localparam int TW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam int IW = (INT_CYCLES > 1) ? $clog2(INT_CYCLES) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(SCAN_CYCLES - 1);
    localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_SCANS - 1);
    localparam logic [IW-1:0] I_LAST = IW'(INT_CYCLES - 1);

    typedef enum logic [1:0] {S_SCAN, S_DEBOUNCE, S_REPORT, S_RELEASE} state_t;
    typedef enum logic [1:0] {R_NONE, R_SINGLE, R_MULTI} res_t;

    logic [2:0]    cols_meta, cols_sync;
    logic          scan_on;
    logic [TW-1:0] timer;
    logic [1:0]    row_idx;
    logic          acc_hit, acc_multi;
    logic [3:0]    acc_code;
    logic          eos;
    res_t          eos_res;
    logic [3:0]    eos_code;
    state_t        state;
    logic [CW-1:0] cnt;
    logic [3:0]    cand;
    logic [3:0]    key_code;
    logic          key_valid, key_overrun, interrupt;
    logic [IW-1:0] int_cnt;

    logic          hit_n, multi_n;
    logic [3:0]    code_n;
    logic [1:0]    col_idx;
    logic [1:0]    nbits;

    function automatic logic [3:0] keymap(input logic [1:0] r, input logic [1:0] c);
        if (r == 2'd3) begin
            case (c)
                2'd0:    return 4'hA;
                2'd1:    return 4'h0;
                default: return 4'hB;
            endcase
        end
        return ({2'b00, r} * 4'd3) + {2'b00, c} + 4'd1;
    endfunction

    // scan_on lags scan_en by one clock so rows drop, and restart at row 0 timer 0,
    // exactly one clock after scan_en changes.
    assign rows = scan_on ? (4'b0001 << row_idx) : 4'b0000;

    // Fold the current row's sample into the running scan result.
    always_comb begin
        nbits   = {1'b0, cols_sync[0]} + {1'b0, cols_sync[1]} + {1'b0, cols_sync[2]};
        col_idx = cols_sync[1] ? 2'd1 : (cols_sync[2] ? 2'd2 : 2'd0);
        hit_n   = acc_hit;
        multi_n = acc_multi;
        code_n  = acc_code;
        if (nbits > 2'd1) begin
            multi_n = 1'b1;
        end else if (nbits == 2'd1) begin
            if (acc_hit) begin
                multi_n = 1'b1;
            end
            hit_n  = 1'b1;
            code_n = keymap(row_idx, col_idx);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cols_meta <= '0;
            cols_sync <= '0;
            scan_on   <= 1'b1;
            timer     <= '0;
            row_idx   <= '0;
            acc_hit   <= 1'b0;
            acc_multi <= 1'b0;
            acc_code  <= '0;
            eos       <= 1'b0;
            eos_res   <= R_NONE;
            eos_code  <= '0;
        end else begin
            cols_meta <= cols;
            cols_sync <= cols_meta;
            eos       <= 1'b0;
            if (!scan_en) begin
                scan_on   <= 1'b0;
                timer     <= '0;
                row_idx   <= '0;
                acc_hit   <= 1'b0;
                acc_multi <= 1'b0;
            end else begin
                scan_on <= 1'b1;
                if (scan_on) begin
                    if (timer == T_LAST) begin
                        timer   <= '0;
                        row_idx <= row_idx + 2'd1;
                        if (row_idx == 2'd3) begin
                            eos       <= 1'b1;
                            eos_res   <= multi_n ? R_MULTI : (hit_n ? R_SINGLE : R_NONE);
                            eos_code  <= code_n;
                            acc_hit   <= 1'b0;
                            acc_multi <= 1'b0;
                        end else begin
                            acc_hit   <= hit_n;
                            acc_multi <= multi_n;
                            acc_code  <= code_n;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_SCAN;
            cnt         <= '0;
            cand        <= '0;
            key_code    <= '0;
            key_valid   <= 1'b0;
            key_overrun <= 1'b0;
            interrupt   <= 1'b0;
            int_cnt     <= '0;
        end else begin
            // The pulse runs to completion independently of scan_en.
            if (interrupt) begin
                if (int_cnt == '0) begin
                    interrupt <= 1'b0;
                end else begin
                    int_cnt <= int_cnt - 1'b1;
                end
            end
            if (cpu.key_ack) begin
                key_valid   <= 1'b0;
                key_overrun <= 1'b0;
            end
            if (!scan_en) begin
                state <= S_SCAN;
                cnt   <= '0;
            end else begin
                case (state)
                    S_SCAN: begin
                        if (eos && eos_res == R_SINGLE) begin
                            cand  <= eos_code;
                            cnt   <= CW'(1);
                            state <= (DEBOUNCE_SCANS <= 1) ? S_REPORT : S_DEBOUNCE;
                        end
                    end
                    S_DEBOUNCE: begin
                        if (eos) begin
                            if (eos_res == R_SINGLE && eos_code == cand) begin
                                cnt <= cnt + 1'b1;
                                if (cnt == C_LAST) begin
                                    state <= S_REPORT;
                                end
                            end else begin
                                cnt   <= '0;
                                state <= S_SCAN;
                            end
                        end
                    end
                    S_REPORT: begin
                        // Overrides a coincident key_ack: the new key stays valid.
                        key_code    <= cand;
                        key_valid   <= 1'b1;
                        key_overrun <= cpu.key_ack ? 1'b0 : (key_overrun | key_valid);
                        interrupt   <= 1'b1;
                        int_cnt     <= I_LAST;
                        cnt         <= '0;
                        state       <= S_RELEASE;
                    end
                    default: begin
                        if (eos) begin
                            if (eos_res == R_NONE) begin
                                if (cnt == C_LAST) begin
                                    cnt   <= '0;
                                    state <= S_SCAN;
                                end else begin
                                    cnt <= cnt + 1'b1;
                                end
                            end else begin
                                cnt <= '0;
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign cpu.key_code    = key_code;
    assign cpu.key_valid   = key_valid;
    assign cpu.key_overrun = key_overrun;
    assign cpu.interrupt   = interrupt;
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb/tb_keypad_scan_ctrl.sv - directed self-checking bench for keypad_scan_ctrl
module tb_keypad_scan_ctrl;
    localparam int SCAN = 16;   // clocks per full 4-row scan at SCAN_CYCLES=4

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       scan_en = 1'b1;
    logic [2:0] cols;
    logic [3:0] rows;
    logic [3:0] press_mask = 4'b0000;
    logic [2:0] press_cols = 3'b000;
    int         n_checks = 0;
    int         n_fail = 0;
    int         int_pulses = 0;
    int         int_high = 0;
    logic       int_prev = 1'b0;
    int         p0, h0;

    keypad_scan_if kif ();

    keypad_scan_ctrl #(
        .SCAN_CYCLES(4),
        .DEBOUNCE_SCANS(2),
        .INT_CYCLES(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .scan_en(scan_en),
        .cols(cols),
        .rows(rows),
        .cpu(kif)
    );

    always #5 clk = ~clk;

    // Keypad model: pressed columns appear only while a pressed row is driven.
    always_comb cols = (|(rows & press_mask)) ? press_cols : 3'b000;

    always @(negedge clk) begin
        if (kif.interrupt) begin
            int_high = int_high + 1;
            if (!int_prev) int_pulses = int_pulses + 1;
        end
        int_prev = kif.interrupt;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic hold_key(input logic [3:0] m, input logic [2:0] c, input int scans);
        press_mask = m;
        press_cols = c;
        repeat (scans * SCAN) @(negedge clk);
        press_mask = 4'b0000;
        press_cols = 3'b000;
        repeat (3 * SCAN) @(negedge clk);
    endtask

    task automatic ack_pulse();
        kif.key_ack = 1'b1;
        @(negedge clk);
        kif.key_ack = 1'b0;
    endtask

    initial begin
        kif.key_ack = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // 1: reset state and idle row rotation
        check_val("rst_key_valid", kif.key_valid, 0);
        check_val("rst_key_code", kif.key_code, 0);
        check_val("rst_overrun", kif.key_overrun, 0);
        check_val("rst_interrupt", kif.interrupt, 0);
        for (int k = 0; k < 2 * SCAN; k++) begin
            check_val($sformatf("idle_rows_%0d", k), rows, 32'(4'b0001 << ((k / 4) % 4)));
            @(negedge clk);
        end
        check_val("idle_no_int", int_pulses, 0);

        // 2: press '5'
        p0 = int_pulses; h0 = int_high;
        hold_key(4'b0010, 3'b010, 3);
        check_val("k5_code", kif.key_code, 5);
        check_val("k5_valid", kif.key_valid, 1);
        check_val("k5_pulses", int_pulses - p0, 1);
        check_val("k5_int_width", int_high - h0, 2);
        ack_pulse();
        check_val("k5_ack_valid", kif.key_valid, 0);

        // 3: short '#' is rejected, '*' accepted
        p0 = int_pulses;
        hold_key(4'b1000, 3'b100, 1);
        check_val("hash_no_int", int_pulses - p0, 0);
        check_val("hash_no_valid", kif.key_valid, 0);
        hold_key(4'b1000, 3'b001, 3);
        check_val("star_code", kif.key_code, 4'hA);
        check_val("star_valid", kif.key_valid, 1);
        check_val("star_pulses", int_pulses - p0, 1);
        ack_pulse();

        // 4: '1'+'2' together never report
        p0 = int_pulses;
        hold_key(4'b0001, 3'b011, 5);
        check_val("multi_no_int", int_pulses - p0, 0);
        check_val("multi_valid", kif.key_valid, 0);
        check_val("multi_code", kif.key_code, 4'hA);

        // 5: overrun
        hold_key(4'b0100, 3'b001, 3);
        check_val("k7_code", kif.key_code, 7);
        check_val("k7_overrun", kif.key_overrun, 0);
        hold_key(4'b0100, 3'b100, 3);
        check_val("k9_code", kif.key_code, 9);
        check_val("k9_valid", kif.key_valid, 1);
        check_val("k9_overrun", kif.key_overrun, 1);
        ack_pulse();
        check_val("ov_ack_valid", kif.key_valid, 0);
        check_val("ov_ack_overrun", kif.key_overrun, 0);

        // 6: long hold, scan_en drop, reset mid-pulse
        p0 = int_pulses;
        press_mask = 4'b0001;
        press_cols = 3'b100;
        repeat (10 * SCAN + 2) @(negedge clk);
        check_val("k3_one_int", int_pulses - p0, 1);
        check_val("k3_code", kif.key_code, 3);
        scan_en = 1'b0;
        @(negedge clk);
        check_val("en_off_rows", rows, 0);
        check_val("en_off_code", kif.key_code, 3);
        check_val("en_off_valid", kif.key_valid, 1);
        ack_pulse();
        scan_en = 1'b1;
        @(negedge clk);
        check_val("en_on_rows", rows, 4'b0001);
        for (int i = 0; i < 10 * SCAN; i++) begin
            if (kif.interrupt) break;
            @(negedge clk);
        end
        check_val("rearm_int_seen", kif.interrupt, 1);
        rst_n = 1'b0;
        #1;
        check_val("rst_mid_int", kif.interrupt, 0);
        check_val("rst_mid_rows", rows, 4'b0001);
        check_val("rst_mid_valid", kif.key_valid, 0);
        check_val("rst_mid_code", kif.key_code, 0);
        press_mask = 4'b0000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
